// File: rtl/fingerprint_lag_comparator.sv
// fingerprint_lag_comparator: best-lag tolerant element-wise match count between two stored sample arrays
module fingerprint_lag_comparator #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 50,
  parameter int TOL = 5,
  parameter int MAX_LAG = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int LW = MAX_LAG > 0 ? $clog2(MAX_LAG + 1) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CW-1:0]               threshold,
  input  logic [DEPTH-1:0][WIDTH-1:0] stored_sample_1,
  input  logic [DEPTH-1:0][WIDTH-1:0] stored_sample_2,
  output logic                        busy,
  output logic                        done,
  output logic [CW-1:0]               best_count,
  output logic [LW-1:0]               best_lag,
  output logic                        compare_sample
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SCAN, NEXT_LAG, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] i, j;
  logic [LW-1:0] l;
  logic [CW-1:0] cnt, thr;
  logic [WIDTH:0] d, ad;
  logic match, last_i, last_l;
  // difference taken one bit wider so a < b yields a proper negative value
  assign j = i + IW'(l);
  assign d = {1'b0, stored_sample_1[i]} - {1'b0, stored_sample_2[j]};
  assign ad = d[WIDTH] ? ~d + (WIDTH+1)'(1) : d;
  assign match = ad <= (WIDTH+1)'(TOL);
  assign last_i = i == IW'(DEPTH - 1) - IW'(l);
  assign last_l = l == LW'(MAX_LAG);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? SCAN : IDLE;
      SCAN:     state_n = last_i ? NEXT_LAG : SCAN;
      NEXT_LAG: state_n = last_l ? DONE : SCAN;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      i <= '0;
      l <= '0;
      cnt <= '0;
      thr <= '0;
      best_count <= '0;
      best_lag <= '0;
      compare_sample <= 1'b0;
    end else case (state)
      IDLE: if (start) begin
        thr <= threshold;
        best_count <= '0;
        best_lag <= '0;
        compare_sample <= 1'b0;
        i <= '0;
        l <= '0;
        cnt <= '0;
      end
      SCAN: begin
        cnt <= cnt + CW'(match);
        if (!last_i) i <= i + IW'(1);
      end
      NEXT_LAG: begin
        // strict compare keeps the smaller lag on ties
        if (cnt > best_count) begin
          best_count <= cnt;
          best_lag <= l;
        end
        if (!last_l) begin
          l <= l + LW'(1);
          i <= '0;
          cnt <= '0;
        end
      end
      default: compare_sample <= best_count >= thr;
    endcase
endmodule

// File: tb/tb_fingerprint_lag_comparator.sv
// tb_fingerprint_lag_comparator: directed and random checks against a lag-scan reference model
module tb_fingerprint_lag_comparator;
  localparam int W = 20, D = 8, T = 5, ML = 2;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] threshold = 0;
  logic [D-1:0][W-1:0] a, b;
  logic busy, done, cs, busy0, done0, cs0;
  logic [3:0] bc, bc0;
  logic [1:0] bl;
  logic [0:0] bl0;
  int cyc = 0, done0_cyc = 0, n_cmp = 0, n_bad = 0;

  fingerprint_lag_comparator #(.WIDTH(W), .DEPTH(D), .TOL(T), .MAX_LAG(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .stored_sample_1(a), .stored_sample_2(b), .busy(busy), .done(done),
    .best_count(bc), .best_lag(bl), .compare_sample(cs));
  fingerprint_lag_comparator #(.WIDTH(W), .DEPTH(D), .TOL(T), .MAX_LAG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .stored_sample_1(a), .stored_sample_2(b), .busy(busy0), .done(done0),
    .best_count(bc0), .best_lag(bl0), .compare_sample(cs0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done0) done0_cyc <= cyc;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int ml, input int thr, output int mbc, output int mbl, output int mcs);
    mbc = 0;
    mbl = 0;
    for (int lag = 0; lag <= ml; lag++) begin
      int c = 0;
      for (int k = 0; k < D - lag; k++) begin
        int df = int'(a[k]) - int'(b[k + lag]);
        if (df <= T && df >= -T) c++;
      end
      if (c > mbc) begin mbc = c; mbl = lag; end
    end
    mcs = int'(mbc >= thr);
  endfunction

  task automatic wait_done(input string tag, output int at);
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, int'(done), 1);
    at = cyc;
  endtask

  task automatic run(input string tag, input int thr, input bit glitch);
    int k, at, mbc, mbl, mcs, zbc, zbl, zcs, extra;
    model(ML, thr, mbc, mbl, mcs);
    model(0, thr, zbc, zbl, zcs);
    @(negedge clk);
    threshold = 4'(thr);
    start = 1;
    k = cyc;
    @(negedge clk);
    start = 0;
    check({tag, "_busy"}, int'(busy), 1);
    if (glitch) begin
      repeat (4) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(tag, at);
    check({tag, "_latency"}, at - k, 25);
    check({tag, "_best_count"}, int'(bc), mbc);
    check({tag, "_best_lag"}, int'(bl), mbl);
    @(negedge clk);
    check({tag, "_compare"}, int'(cs), mcs);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_lag0_count"}, int'(bc0), zbc);
    check({tag, "_lag0_compare"}, int'(cs0), zcs);
    check({tag, "_lag0_latency"}, done0_cyc - k, 10);
    if (glitch) begin
      extra = 0;
      repeat (30) begin @(negedge clk); extra += int'(done); end
      check({tag, "_single_done"}, extra, 0);
    end
  endtask

  initial begin
    int d1, d2, extra, mbc, mbl, mcs;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_count", int'(bc), 0);
    check("reset_lag", int'(bl), 0);
    check("reset_compare", int'(cs), 0);
    rst = 0;
    for (int k = 0; k < D; k++) begin a[k] = W'(k); b[k] = W'(k); end
    run("identical", 8, 0);
    for (int k = 0; k < D; k++) begin a[k] = W'(100 + 10 * k); b[k] = W'(100 + 10 * k + (k % 2 == 0 ? 5 : 6)); end
    run("tol_edge", 8, 0);
    for (int k = 0; k < D; k++) begin a[k] = 3; b[k] = 0; end
    run("no_underflow", 8, 0);
    for (int k = 0; k < D; k++) a[k] = W'(1000 + 50 * k);
    b[0] = 20'hFFFFF;
    b[1] = 20'hFFF00;
    for (int k = 0; k < D - 2; k++) b[k + 2] = a[k];
    run("shifted", 6, 0);
    for (int k = 0; k < D; k++) a[k] = k < 6 ? 0 : 1000;
    for (int k = 0; k < D; k++) b[k] = (k == 0 || k >= 6) ? 9000 : 0;
    run("tie", 6, 0);
    run("tie_thr0", 0, 0);
    run("start_glitch", 5, 1);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < D; k++) begin a[k] = W'($urandom_range(0, 30)); b[k] = W'($urandom_range(0, 30)); end
      run($sformatf("rand%0d", r), $urandom_range(0, 9), 0);
    end
    for (int k = 0; k < D; k++) begin a[k] = W'(k); b[k] = W'(k); end
    @(negedge clk);
    threshold = 8;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_count", int'(bc), 0);
    check("abort_lag", int'(bl), 0);
    check("abort_compare", int'(cs), 0);
    extra = 0;
    repeat (30) begin @(negedge clk); extra += int'(done); end
    check("abort_no_done", extra, 0);
    run("after_abort", 8, 0);
    for (int k = 0; k < D; k++) b[k] = W'(k + 2);
    model(ML, 3, mbc, mbl, mcs);
    @(negedge clk);
    threshold = 3;
    start = 1;
    wait_done("b2b_first", d1);
    check("b2b_count", int'(bc), mbc);
    @(negedge clk);
    check("b2b_compare_held", int'(cs), mcs);
    @(negedge clk);
    check("b2b_restart_busy", int'(busy), 1);
    check("b2b_restart_count", int'(bc), 0);
    check("b2b_restart_lag", int'(bl), 0);
    check("b2b_restart_compare", int'(cs), 0);
    wait_done("b2b_second", d2);
    start = 0;
    check("b2b_spacing", d2 - d1, 26);
    check("b2b_count2", int'(bc), mbc);
    check("b2b_lag2", int'(bl), mbl);
    repeat (2) @(negedge clk);
    check("b2b_idle", int'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
